alu_sequencer: RTL

Multi-cycle control unit that runs a small program from instruction memory through the combinational ALU. Fetches a 16-bit instruction over a request/valid handshake, decodes it, reads a 4 x 8-bit register file, drives the ALU operand/opcode ports, and writes the result back. Also handles the control opcodes NOP, JUMP, JUMPZERO and HALT. Sits between instruction memory and the ALU; it is the top-level sequencer of the CPU core.

---
 rtl/puc_pkg.sv | 36 +++
 rtl/alu_sequencer_register_file.sv | 28 ++
 rtl/alu_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/puc_pkg.sv
// puc_pkg: shared opcodes, FSM states, instruction field positions and width defaults
//   for alu_sequencer and its register file.
package puc_pkg;
    localparam int REGISTER_WIDTH = 8;
    localparam int OPCODE_WIDTH = 4;
    localparam int ADDRESS_WIDTH = 8;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LOADSWITCH = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_LSHIFT = 4'd4;
    localparam logic [3:0] OP_RSHIFT = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DECREMENT = 4'd7;
    localparam logic [3:0] OP_JUMP = 4'd8;
    localparam logic [3:0] OP_JUMPZERO = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 10;
    localparam int RS_MSB = 9;
    localparam int RS_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALTED = 3'd4
    } alu_state_t;
    function automatic logic is_alu_op(input logic [3:0] op);
        return op >= OP_LOADSWITCH && op <= OP_DECREMENT;
    endfunction
endpackage

// File: rtl/alu_sequencer_register_file.sv
// register_file: REGISTER_COUNT x REGISTER_WIDTH registers, two combinational read ports,
//   one synchronous write port (writeEnable/writeIndex/writeValue), async clear on reset.
module register_file #(
    parameter int REGISTER_COUNT = 4,
    parameter int REGISTER_WIDTH = puc_pkg::REGISTER_WIDTH,
    parameter int INDEX_WIDTH = $clog2(REGISTER_COUNT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [INDEX_WIDTH-1:0]    read1Index,
    input  logic [INDEX_WIDTH-1:0]    read2Index,
    output logic [REGISTER_WIDTH-1:0] read1Value,
    output logic [REGISTER_WIDTH-1:0] read2Value,
    input  logic                      writeEnable,
    input  logic [INDEX_WIDTH-1:0]    writeIndex,
    input  logic [REGISTER_WIDTH-1:0] writeValue
);
    logic [REGISTER_WIDTH-1:0] regs [REGISTER_COUNT];
    for (genvar g = 0; g < REGISTER_COUNT; g++) begin : gen_reg
        always_ff @(posedge clock or posedge reset)
            if (reset)
                regs[g] <= '0;
            else if (writeEnable && writeIndex == INDEX_WIDTH'(g))
                regs[g] <= writeValue;
    end
    assign read1Value = regs[read1Index];
    assign read2Value = regs[read2Index];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/writeback control unit driving an external combinational ALU.
//   clock/reset/enable: control; instrRequest/instrAddress/instrValid/instrData: fetch handshake;
//   aluOpCode/aluRegister1Value/aluRegister2Value/aluInstructionValue/aluResult: ALU link;
//   programCounter: current PC; halted: high once HALT has executed.
module alu_sequencer #(
    parameter int REGISTER_WIDTH = puc_pkg::REGISTER_WIDTH,
    parameter int OPCODE_WIDTH = puc_pkg::OPCODE_WIDTH,
    parameter int ADDRESS_WIDTH = puc_pkg::ADDRESS_WIDTH,
    parameter int REGISTER_COUNT = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    output logic                      instrRequest,
    output logic [ADDRESS_WIDTH-1:0]  instrAddress,
    input  logic                      instrValid,
    input  logic [15:0]               instrData,
    output logic [OPCODE_WIDTH-1:0]   aluOpCode,
    output logic [REGISTER_WIDTH-1:0] aluRegister1Value,
    output logic [REGISTER_WIDTH-1:0] aluRegister2Value,
    output logic [REGISTER_WIDTH-1:0] aluInstructionValue,
    input  logic [REGISTER_WIDTH-1:0] aluResult,
    output logic [ADDRESS_WIDTH-1:0]  programCounter,
    output logic                      halted
);
    import puc_pkg::*;
    localparam int IW = $clog2(REGISTER_COUNT);
    alu_state_t state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [15:0] instr;
    logic [REGISTER_WIDTH-1:0] wb_value;
    logic [REGISTER_WIDTH-1:0] rd_value;
    logic [REGISTER_WIDTH-1:0] rs_value;
    logic jump_taken;
    register_file #(
        .REGISTER_COUNT(REGISTER_COUNT),
        .REGISTER_WIDTH(REGISTER_WIDTH),
        .INDEX_WIDTH(IW)
    ) u_regs (
        .clock(clock),
        .reset(reset),
        .read1Index(instr[RD_MSB:RD_LSB]),
        .read2Index(instr[RS_MSB:RS_LSB]),
        .read1Value(rd_value),
        .read2Value(rs_value),
        .writeEnable(state == ST_WRITEBACK),
        .writeIndex(instr[RD_MSB:RD_LSB]),
        .writeValue(wb_value)
    );
    // Reset gates the request directly so it drops in the same cycle reset rises.
    assign instrRequest = enable && state == ST_FETCH && !reset;
    assign instrAddress = pc;
    assign programCounter = pc;
    assign halted = state == ST_HALTED;
    // In WRITEBACK the opcode is an ALU op, so jump_taken is 0 and pc_next is PC+1.
    assign jump_taken = aluOpCode == OP_JUMP || (aluOpCode == OP_JUMPZERO && aluRegister1Value == '0);
    assign pc_next = jump_taken ? ADDRESS_WIDTH'(aluInstructionValue) : pc + ADDRESS_WIDTH'(1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH;
            pc <= '0;
            instr <= '0;
            wb_value <= '0;
            aluOpCode <= '0;
            aluRegister1Value <= '0;
            aluRegister2Value <= '0;
            aluInstructionValue <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (instrRequest && instrValid) begin
                        instr <= instrData;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    aluOpCode <= instr[OPCODE_MSB:OPCODE_LSB];
                    aluRegister1Value <= rd_value;
                    aluRegister2Value <= rs_value;
                    aluInstructionValue <= REGISTER_WIDTH'(instr[IMM_MSB:IMM_LSB]);
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (is_alu_op(aluOpCode)) begin
                        wb_value <= aluResult;
                        state <= ST_WRITEBACK;
                    end else if (aluOpCode == OP_HALT) begin
                        state <= ST_HALTED;
                    end else begin
                        pc <= pc_next;
                        state <= ST_FETCH;
                    end
                end
                ST_WRITEBACK: begin
                    pc <= pc_next;
                    state <= ST_FETCH;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end
endmodule
